// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-drain stage: data word width, the data word
// type and the skid-buffer occupancy encoding.
package fifo_pkg;

    // FIFO data buses are DATA_WIDTH+1 bits wide ([DATA_WIDTH:0]).
    localparam int unsigned DATA_WIDTH = 7;

    // Number of words currently held in the 2-entry skid buffer.
    typedef enum logic [1:0] {
        OCC0 = 2'd0,
        OCC1 = 2'd1,
        OCC2 = 2'd2
    } occ_e;

    typedef logic [DATA_WIDTH:0] fifo_word_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order register buffer. entry0 is always the oldest word and
// drives head_data; a pop shifts entry1 down. A simultaneous write and pop
// keeps occupancy and shifts data. The caller guarantees no write at OCC2
// without a pop.
module fifo_skid_buf (
    input  logic                 clk,
    input  logic                 rst,        // asynchronous, active-low
    input  logic                 wr_en,
    input  fifo_pkg::fifo_word_t wr_data,
    input  logic                 pop,
    output fifo_pkg::occ_e       occ,
    output fifo_pkg::fifo_word_t head_data
);
    import fifo_pkg::*;

    occ_e       occ_q, occ_d;
    fifo_word_t entry0_q, entry0_d;
    fifo_word_t entry1_q, entry1_d;
    logic       pop_eff;

    // A pop against an empty buffer has no meaning; ignore it.
    assign pop_eff = pop && (occ_q != OCC0);

    // Next occupancy and entry contents from the write/pop combination.
    always_comb begin
        occ_d    = occ_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        case ({wr_en, pop_eff})
            2'b10: begin
                case (occ_q)
                    OCC0: begin
                        entry0_d = wr_data;
                        occ_d    = OCC1;
                    end
                    OCC1: begin
                        entry1_d = wr_data;
                        occ_d    = OCC2;
                    end
                    default: begin
                        occ_d = occ_q;
                    end
                endcase
            end
            2'b01: begin
                entry0_d = entry1_q;
                occ_d    = (occ_q == OCC2) ? OCC1 : OCC0;
            end
            2'b11: begin
                if (occ_q == OCC2) begin
                    entry0_d = entry1_q;
                    entry1_d = wr_data;
                end else begin
                    entry0_d = wr_data;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // Buffer state registers; reset discards any held words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q    <= OCC0;
            entry0_q <= '0;
            entry1_q <= '0;
        end else begin
            occ_q    <= occ_d;
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = entry0_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain stage for a synchronous FIFO. Issues rd_en pops only when
// the skid buffer is guaranteed room for the word that arrives a cycle later,
// and presents buffered words as a valid/ready stream.
// Optional feature: define FIFO_DRAIN_CNT_EN to add the beat_cnt port, a
// CNT_WIDTH-bit wrapping count of accepted output beats.
module fifo_rd_drain #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,            // asynchronous, active-low
    input  logic                 drain_en,
    input  logic                 fifo_empty,
    input  fifo_pkg::fifo_word_t fifo_data_out,
    output logic                 fifo_rd_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output fifo_pkg::fifo_word_t m_data
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] beat_cnt
`endif
);
    import fifo_pkg::*;

    occ_e       occ;
    fifo_word_t head_data;
    logic       inflight_q, inflight_d;
    logic       pop;
    logic [2:0] commit;

    assign m_valid = (occ != OCC0);
    assign m_data  = head_data;
    assign pop     = m_valid && m_ready;

    // Words the buffer will hold after this edge if no new pop is issued.
    // occ + inflight never drops below pop, so this cannot underflow.
    assign commit = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

    // Pop only with room for the returning word; held low through reset so
    // the FIFO sees no request while state is being cleared.
    always_comb begin
        fifo_rd_en = rst && drain_en && !fifo_empty && (commit < 3'd2);
        inflight_d = fifo_rd_en;
    end

    // Track the pop whose data appears on fifo_data_out next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (inflight_q),
        .wr_data   (fifo_data_out),
        .pop       (pop),
        .occ       (occ),
        .head_data (head_data)
    );

`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

    // Count accepted beats, wrapping naturally at 2^CNT_WIDTH.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (pop) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule
